// File: rtl/seq_multiplier_4_if.sv
// Start/done handshake bundle for the 4x4 sequential multiplier.
// The master drives the request and operands; the slave returns status and the product.
interface seq_multiplier_4_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] product;

  modport master (output start, output A, output B, input busy, input done, input product);
  modport slave  (input start, input A, input B, output busy, output done, output product);
endinterface

// File: rtl/seq_multiplier_4.sv
// 4x4 unsigned shift-and-add multiplier built around the 4-bit ripple adder.
// It runs one add/shift step per clock for four clocks and then pulses done for one cycle.
module full_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       co
);
  // ripple carry chain
  always_comb begin
    logic carry_v;
    carry_v = cin;
    sum     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = A[i] ^ B[i] ^ carry_v;
      carry_v = (A[i] & B[i]) | (carry_v & (A[i] ^ B[i]));
    end
    co = carry_v;
  end
endmodule

module seq_multiplier_4 #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_multiplier_4_if.slave  bus
);
  if (N != 4) begin : g_bad_width
    $error("seq_multiplier_4: only N=4 is supported (tied to the 4-bit adder)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] m_r, q_r, acc_r;
  logic [1:0] cnt_r;
  logic       busy_r, done_r, busy_s, done_s;
  logic [7:0] product_r;
  logic [3:0] sum_s;
  logic       co_s;
  logic [7:0] shift_s;

  full_adder u_adder (
    .A   (acc_r),
    .B   (m_r),
    .cin (1'b0),
    .sum (sum_s),
    .co  (co_s)
  );

  // Carry is folded into the shifted value, so 15*15 never loses a bit.
  assign shift_s = q_r[0] ? {co_s, sum_s, q_r[3:1]} : {1'b0, acc_r, q_r[3:1]};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_s = CALC; else state_s = IDLE;
      CALC:    if (cnt_r == 2'd3) state_s = DONE; else state_s = CALC;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // output decode from the upcoming state, registered below
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      CALC:    busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r       <= 4'd0;
      q_r       <= 4'd0;
      acc_r     <= 4'd0;
      cnt_r     <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= 8'd0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            m_r   <= bus.A;
            q_r   <= bus.B;
            acc_r <= 4'd0;
            cnt_r <= 2'd0;
          end
        end
        CALC: begin
          acc_r <= shift_s[7:4];
          q_r   <= shift_s[3:0];
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) product_r <= shift_s;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule

// File: tb/tb_seq_multiplier_4.sv
// Directed self-checking bench for seq_multiplier_4: latency, product values,
// ignored starts, mid-operation reset, back-to-back throughput and an exhaustive sweep.
module tb_seq_multiplier_4;
  logic clk;
  logic rst;
  int   checks_r;
  int   errors_r;

  seq_multiplier_4_if bus ();

  seq_multiplier_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic b, input logic d);
    check_val({tag, "_busy"}, {7'd0, bus.busy}, {7'd0, b});
    check_val({tag, "_done"}, {7'd0, bus.done}, {7'd0, d});
  endtask

  // one start pulse; walks the edges after acceptance and checks the exact latency
  task automatic do_mul(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_status({tag, "_e0"}, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        check_status($sformatf("%s_e%0d", tag, i), 1'b1, 1'b0);
      end else if (i == 4) begin
        check_status({tag, "_e4"}, 1'b0, 1'b1);
        check_val({tag, "_prod"}, bus.product, exp);
      end else begin
        check_status({tag, "_e5"}, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    rst = 1'b1; bus.start = 1'b0; bus.A = 4'd0; bus.B = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_status("reset", 1'b0, 1'b0);
    check_val("reset_prod", bus.product, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    do_mul(4'hF, 4'hF, 8'hE1, "ff");
    repeat (3) @(posedge clk);
    #1;
    check_val("ff_hold", bus.product, 8'hE1);
    check_status("ff_idle", 1'b0, 1'b0);

    do_mul(4'h9, 4'h0, 8'h00, "b_zero");
    do_mul(4'h0, 4'hD, 8'h00, "a_zero");
    do_mul(4'h1, 4'h1, 8'h01, "one");
    do_mul(4'hC, 4'h5, 8'h3C, "c5");

    // start held with changing operands while busy: must be ignored
    bus.A = 4'h7; bus.B = 4'h6; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.A = 4'hF; bus.B = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      bus.A = ~bus.A; bus.B = bus.B ^ 4'h5;
      if (i == 4) begin
        check_status("ign_e4", 1'b0, 1'b1);
        check_val("ign_prod", bus.product, 8'h2A);
      end else if (i == 5) begin
        bus.start = 1'b0;
        check_status("ign_e5", 1'b0, 1'b0);
      end else begin
        check_status($sformatf("ign_e%0d", i), 1'b1, 1'b0);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    check_status("ign_nosecond", 1'b0, 1'b0);
    check_val("ign_hold", bus.product, 8'h2A);

    // reset sampled on the 2nd CALC edge abandons the operation
    bus.A = 4'hB; bus.B = 4'hD; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_status("rst_mid", 1'b0, 1'b0);
    check_val("rst_mid_prod", bus.product, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_status($sformatf("rst_quiet%0d", i), 1'b0, 1'b0);
    end
    do_mul(4'h3, 4'h3, 8'h09, "after_rst");

    // back-to-back with start held high: acceptances every 6 edges
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] exp_v;
      case (k)
        0:       begin bus.A = 4'h2; bus.B = 4'h3; exp_v = 8'h06; end
        1:       begin bus.A = 4'hF; bus.B = 4'h1; exp_v = 8'h0F; end
        default: begin bus.A = 4'h8; bus.B = 4'h8; exp_v = 8'h40; end
      endcase
      @(posedge clk); #1;
      check_status($sformatf("b2b%0d_e0", k), 1'b1, 1'b0);
      bus.A = 4'h0; bus.B = 4'h0;
      for (int i = 1; i <= 5; i++) begin
        @(posedge clk); #1;
        if (i == 4) begin
          check_status($sformatf("b2b%0d_e4", k), 1'b0, 1'b1);
          check_val($sformatf("b2b%0d_prod", k), bus.product, exp_v);
        end else if (i == 5) begin
          check_status($sformatf("b2b%0d_e5", k), 1'b0, 1'b0);
        end else begin
          check_status($sformatf("b2b%0d_e%0d", k, i), 1'b1, 1'b0);
        end
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] av, bv;
        logic [7:0] pv;
        av = a[3:0]; bv = b[3:0]; pv = 8'(a * b);
        do_mul(av, bv, pv, $sformatf("sw_%h_%h", av, bv));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end
endmodule
